// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer that owns HI/LO and holds Busy for a fixed cycle count.
// Build option: define MD_DIVZERO_HOLD_EN to keep HI/LO unchanged on divide-by-zero.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Busy,
  output logic        Pending,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0] LP_MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] LP_DIV_N  = 4'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_rhi;
  logic [31:0] r_rlo;

  logic        w_md_op;
  logic        w_go;
  logic [63:0] w_sa;
  logic [63:0] w_sb;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_b_zero;
  logic [31:0] w_b_safe;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_sq_mag;
  logic [31:0] w_sr_mag;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_dz_hi;
  logic [31:0] w_dz_lo;

  assign w_md_op = (MDop >= OP_MULT) && (MDop <= OP_DIVU);
  assign w_go    = Start & ~Req;
  assign Busy    = (r_state == S_BUSY);
  assign Pending = Busy | (w_go & w_md_op);
  assign HI      = r_hi;
  assign LO      = r_lo;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign w_sa     = {{32{A[31]}}, A};
  assign w_sb     = {{32{B[31]}}, B};
  assign w_prod_s = w_sa * w_sb;
  assign w_prod_u = {32'h0, A} * {32'h0, B};

  // Signed divide on magnitudes; 0x80000000 / -1 naturally yields 0x80000000 rem 0.
  assign w_b_zero = (B == 32'h0);
  assign w_b_safe = w_b_zero ? 32'h1 : B;
  assign w_a_mag  = A[31] ? (32'h0 - A) : A;
  assign w_b_mag  = w_b_safe[31] ? (32'h0 - w_b_safe) : w_b_safe;
  assign w_sq_mag = w_a_mag / w_b_mag;
  assign w_sr_mag = w_a_mag % w_b_mag;
  assign w_sq     = (A[31] ^ w_b_safe[31]) ? (32'h0 - w_sq_mag) : w_sq_mag;
  assign w_sr     = A[31] ? (32'h0 - w_sr_mag) : w_sr_mag;
  assign w_uq     = A / w_b_safe;
  assign w_ur     = A % w_b_safe;

`ifdef MD_DIVZERO_HOLD_EN
  // HI/LO cannot move while busy, so capturing them now equals holding at commit.
  assign w_dz_hi = r_hi;
  assign w_dz_lo = r_lo;
`else
  assign w_dz_hi = A;
  assign w_dz_lo = 32'hFFFF_FFFF;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_hi    <= 32'h0;
      r_lo    <= 32'h0;
      r_rhi   <= 32'h0;
      r_rlo   <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            case (MDop)
              OP_MULT: begin
                {r_rhi, r_rlo} <= w_prod_s;
                r_cnt          <= LP_MULT_N;
                r_state        <= S_BUSY;
              end
              OP_MULTU: begin
                {r_rhi, r_rlo} <= w_prod_u;
                r_cnt          <= LP_MULT_N;
                r_state        <= S_BUSY;
              end
              OP_DIV: begin
                r_rhi   <= w_b_zero ? w_dz_hi : w_sr;
                r_rlo   <= w_b_zero ? w_dz_lo : w_sq;
                r_cnt   <= LP_DIV_N;
                r_state <= S_BUSY;
              end
              OP_DIVU: begin
                r_rhi   <= w_b_zero ? w_dz_hi : w_ur;
                r_rlo   <= w_b_zero ? w_dz_lo : w_uq;
                r_cnt   <= LP_DIV_N;
                r_state <= S_BUSY;
              end
              OP_MTHI: r_hi <= A;
              OP_MTLO: r_lo <= A;
              default: ;
            endcase
          end
        end
        default: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_hi    <= r_rhi;
            r_lo    <= r_rlo;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: expected HI/LO queued at issue, compared at commit.
module tb_md_sequencer;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  MDop = 3'd0;
  logic [31:0] A = 32'h0;
  logic [31:0] B = 32'h0;
  logic        Req = 1'b0;
  logic        Busy;
  logic        Pending;
  logic [31:0] HI;
  logic [31:0] LO;

  md_sequencer #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDop(MDop), .A(A), .B(B),
    .Req(Req), .Busy(Busy), .Pending(Pending), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_pass = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b, hi, lo);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, r64, q64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      3'd1: return 64'(sa * sb);
      3'd2: return ua * ub;
      3'd3, 3'd4: begin
        if (b == 32'h0) begin
`ifdef MD_DIVZERO_HOLD_EN
          return {hi, lo};
`else
          return {a, 32'hFFFF_FFFF};
`endif
        end
        if (op == 3'd3) begin
          sq = sa / sb;
          sr = sa % sb;
          q64 = 64'(sq);
          r64 = 64'(sr);
        end else begin
          q64 = ua / ub;
          r64 = ua % ub;
        end
        return {r64[31:0], q64[31:0]};
      end
      default: return {hi, lo};
    endcase
  endfunction

  // inj: 0 none, 1 Req pulse mid-op, 2 mtlo attempted mid-op
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, b,
                        input logic [63:0] exp, input int n, input int inj);
    int busy_n;
    logic [31:0] hi0, lo0;
    logic stable;
    sb_q.push_back(exp);
    @(negedge clk);
    Start = 1'b1; MDop = op; A = a; B = b; Req = 1'b0;
    #1 chk({tag, "_pending"}, {63'h0, Pending}, 64'h1);
    @(posedge clk); #1;
    Start = 1'b0; MDop = 3'd0;
    hi0 = HI; lo0 = LO;
    busy_n = 0;
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!Busy) break;
      busy_n++;
      if (HI !== hi0 || LO !== lo0) stable = 1'b0;
      Req = (i == 1 && inj == 1);
      if (i == 1 && inj == 2) begin
        Start = 1'b1; MDop = 3'd6; A = 32'hDEAD_BEEF;
      end else begin
        Start = 1'b0; MDop = 3'd0;
      end
      @(posedge clk); #1;
    end
    Req = 1'b0; Start = 1'b0; MDop = 3'd0;
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(n));
    chk({tag, "_hilo_stable"}, {63'h0, stable}, 64'h1);
    chk({tag, "_result"}, {HI, LO}, sb_q.pop_front());
    {m_hi, m_lo} = exp;
  endtask

  task automatic mt(input string tag, input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    Start = 1'b1; MDop = op; A = a;
    #1 chk({tag, "_pending"}, {63'h0, Pending}, 64'h0);
    @(posedge clk); #1;
    Start = 1'b0; MDop = 3'd0;
    if (op == 3'd5) m_hi = a; else m_lo = a;
    chk({tag, "_busy"}, {63'h0, Busy}, 64'h0);
    chk({tag, "_hilo"}, {HI, LO}, {m_hi, m_lo});
  endtask

  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    #1;
    chk("rst_busy", {63'h0, Busy}, 64'h0);
    chk("rst_pending", {63'h0, Pending}, 64'h0);
    chk("rst_hilo", {HI, LO}, 64'h0);
    @(negedge clk); reset = 1'b0;

    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, NM, 0);
    run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, NM, 0);
    run_op("div_req", 3'd3, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, ND, 1);
    run_op("divu", 3'd4, 32'd7, 32'd2, 64'h0000_0001_0000_0003, ND, 0);
    mt("mthi", 3'd5, 32'h1234_5678);
    run_op("mult_mtlo", 3'd1, 32'h10, 32'h10, 64'h0000_0000_0000_0100, NM, 2);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, ND, 0);

    @(negedge clk);
    Start = 1'b1; MDop = 3'd1; A = 32'd5; B = 32'd7; Req = 1'b1;
    #1 chk("req_pending", {63'h0, Pending}, 64'h0);
    @(posedge clk); #1;
    Start = 1'b0; MDop = 3'd0; Req = 1'b0;
    chk("req_busy", {63'h0, Busy}, 64'h0);
    @(posedge clk); #1;
    chk("req_hilo", {HI, LO}, {m_hi, m_lo});

    mt("mthi_dz", 3'd5, 32'hAAAA_0000);
    mt("mtlo_dz", 3'd6, 32'h0000_5555);
`ifdef MD_DIVZERO_HOLD_EN
    run_op("div_zero", 3'd3, 32'h1234, 32'h0, 64'hAAAA_0000_0000_5555, ND, 0);
`else
    run_op("div_zero", 3'd3, 32'h1234, 32'h0, 64'h0000_1234_FFFF_FFFF, ND, 0);
`endif

    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(1, 4));
      a = $urandom();
      b = (i == 5) ? 32'h0 : $urandom();
      if (i == 2) b = 32'hFFFF_FFF3;
      run_op("rand", op, a, b, model(op, a, b, m_hi, m_lo),
             (op <= 3'd2) ? NM : ND, 0);
    end

    mt("mthi_pre_rst", 3'd5, 32'hCAFE_0001);
    @(negedge clk);
    Start = 1'b1; MDop = 3'd1; A = 32'h7; B = 32'h9;
    @(posedge clk); #1;
    Start = 1'b0; MDop = 3'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy", {63'h0, Busy}, 64'h0);
    chk("midrst_hilo", {HI, LO}, 64'h0);
    chk("midrst_state", {dut.r_rhi, dut.r_rlo}, 64'h0);
    chk("midrst_cnt", {59'h0, dut.r_state, dut.r_cnt}, 64'h0);
    @(negedge clk); reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_nocommit", {31'h0, Busy, HI}, 64'h0);
    chk("midrst_lo", {32'h0, LO}, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide sequencer for the pipelined MIPS core. It owns the HI/LO registers and runs mult/multu/div/divu over a fixed number of cycles while asserting `Busy`. The hazard unit uses `Busy` to stall later MD-class instructions. It sits beside the ALU in the E stage and honours the exception request `Req`, so a faulting instruction never starts an operation.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (legal 1..15).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (legal 1..15).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Start`  in  1  E-stage instruction is an MD-class instruction.
- `MDop`  in  3  operation: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 0 and 7 mean no-op.
- `A`  in  32  rs operand (forwarded).
- `B`  in  32  rt operand (forwarded).
- `Req`  in  1  exception/interrupt request this cycle; suppresses a new start.
- `Busy`  out  1  registered; an operation is in flight.
- `Pending`  out  1  combinational; equals `Busy | (Start & ~Req & MDop in 1..4)`. Used by the stall logic.
- `HI`  out  32  registered HI value.
- `LO`  out  32  registered LO value.

## Operation
- States: IDLE and BUSY. A 4-bit down-counter `cnt` runs alongside. Internal result registers `rhi`/`rlo` hold the result until commit.
- Reset, asynchronous: state IDLE, `cnt`=0, `Busy`=0, `HI`=0, `LO`=0, `rhi`=0, `rlo`=0.
- IDLE, edge with `Start & ~Req`:
  - mult/multu: `{rhi,rlo}` = 64-bit signed/unsigned product. `cnt`=`MULT_CYCLES`. Go to BUSY.
  - div/divu: `rlo` = signed/unsigned quotient, `rhi` = remainder. Signed remainder takes the sign of the dividend. `cnt`=`DIV_CYCLES`. Go to BUSY.
  - mthi: `HI` = `A` at this edge; stay IDLE. mtlo: `LO` = `A`; stay IDLE.
  - MDop 0 or 7: no effect.
- BUSY, every edge: `cnt` = `cnt`-1. At the edge where `cnt`==1, `HI`=`rhi`, `LO`=`rlo`, and the state returns to IDLE.
- `Start` while BUSY is ignored entirely, including mthi/mtlo. The hazard unit guarantees this never occurs legally.
- `Req` with `Start` in the same cycle: no operation starts and HI/LO are unchanged.
- `Req` while BUSY: the in-flight operation completes and commits normally, because it belongs to an older, committed instruction.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.

## Timing
- Start sampled at edge k: `Busy`=1 from edge k through edge k+N-1, where N = cycle parameter. At edge k+N, `HI`/`LO` take the new values and `Busy` falls.
- `Busy`=1 for exactly N cycles; there is no gap cycle. A new Start is accepted in the cycle in which `Busy` has just fallen.
- mthi/mtlo take effect in one edge, and the new value is visible in the following cycle.
- `HI`/`LO` never change while `Busy`=1. mfhi/mflo read them combinationally and are stalled by `Pending`.
- Reset asserted mid-operation aborts it immediately: outputs return to their reset values and no commit occurs.

## Configuration
- `MD_DIVZERO_HOLD_EN` defined: div/divu with `B`==0 still runs for `DIV_CYCLES`, but HI and LO keep their previous values at commit.
- Macro undefined: div/divu with `B`==0 commits LO=0xFFFFFFFF and HI=`A`. This is deterministic, never X.

## Test plan
- Reset, then mult with A=0xFFFFFFFE (−2) and B=3: `Busy` is high for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA. Repeating with multu gives HI=0x00000002 and LO=0xFFFFFFFA.
- div with A=0xFFFFFFF9 (−7) and B=2: after 10 cycles LO=0xFFFFFFFD and HI=0xFFFFFFFF. divu with A=7 and B=2 gives LO=3 and HI=1.
- mthi with A=0x12345678 in IDLE: HI=0x12345678 one edge later and `Busy` stays 0. mtlo issued while BUSY is ignored, so LO is unchanged.
- Start=1, MDop=1, Req=1 in the same cycle: `Busy` stays 0, `Pending`=0 and HI/LO are unchanged. `Req` pulsed during a div does not stop the div committing on schedule.
- div with B=0 and HI=0xAAAA0000, LO=0x5555: with the macro the values are unchanged after 10 cycles. Without it, LO=0xFFFFFFFF and HI=A.
- Assert reset during cycle 3 of a mult: `Busy`, HI, LO and the internal state all read 0 immediately, and no commit follows.
